// File: rtl/shop_pkg.sv
// Shared definitions for the shop tokenizer and the command FSM.
// Holds ASCII constants, tokenizer states, default widths and char classes.
package shop_pkg;

  localparam int DEF_NUM_ASCII_CHARS = 7;
  localparam int DEF_U_NUM_BITS      = 4;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_DEL   = 8'h7F;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT,
    DRAIN
  } tok_state_t;

  function automatic logic is_delim(logic [7:0] c);
    return (c == CHAR_SPACE) || (c == CHAR_CR) || (c == CHAR_LF);
  endfunction

  function automatic logic is_print(logic [7:0] c);
    return (c >= 8'h21) && (c <= 8'h7E);
  endfunction

  function automatic logic is_digit(logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_bksp(logic [7:0] c);
    return (c == CHAR_BS) || (c == CHAR_DEL);
  endfunction

endpackage

// File: rtl/shop_dec_acc.sv
// Digit flag / decimal accumulator with a sticky too_big flag.
// Ports: i_clk, i_reset, clr, load (first char), step (next char), ch;
// with SHOP_TOKENIZER_BACKSPACE_EN also recalc, word, len (rebuild
// from the packed word). Outputs value and valid.
module shop_dec_acc
  import shop_pkg::*;
#(
  parameter int N = DEF_NUM_ASCII_CHARS,
  parameter int U = DEF_U_NUM_BITS
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   clr,
  input  logic                   load,
  input  logic                   step,
  input  logic [7:0]             ch,
`ifdef SHOP_TOKENIZER_BACKSPACE_EN
  input  logic                   recalc,
  input  logic [N*8-1:0]         word,
  input  logic [$clog2(N+1)-1:0] len,
`endif
  output logic [U-1:0]           value,
  output logic                   valid
);

  localparam int W = U + 5;
  localparam logic [W-1:0] MAXV = W'((2 ** U) - 1);

  typedef struct packed {
    logic [U:0] acc;
    logic       dg;
    logic       tb;
  } num_t;

  localparam num_t ZERO  = '{acc: '0, dg: 1'b0, tb: 1'b0};
  localparam num_t FIRST = '{acc: '0, dg: 1'b1, tb: 1'b0};

  // Once too_big is set the value is frozen; only the digit flag moves.
  function automatic num_t num_step(num_t s, logic [7:0] c);
    num_t         r;
    logic [W-1:0] p;
    r = s;
    p = W'(s.acc) * W'(10) + W'(c[3:0]);
    if (!is_digit(c)) begin
      r.dg = 1'b0;
    end else if (!s.tb) begin
      r.acc = p[U:0];
      r.tb  = (p > MAXV);
    end
    return r;
  endfunction

`ifdef SHOP_TOKENIZER_BACKSPACE_EN
  // Replays the surviving chars, oldest (leftmost) first.
  function automatic num_t num_rebuild(
    logic [N*8-1:0] w,
    logic [$clog2(N+1)-1:0] n
  );
    num_t r;
    r = FIRST;
    for (int i = N - 1; i >= 0; i--) begin
      if (i < int'(n)) r = num_step(r, w[i*8 +: 8]);
    end
    return r;
  endfunction
`endif

  num_t cur;
  num_t nxt;

  always_comb begin
    nxt = cur;
    if (clr) begin
      nxt = ZERO;
    end else if (load) begin
      nxt = num_step(FIRST, ch);
`ifdef SHOP_TOKENIZER_BACKSPACE_EN
    end else if (recalc) begin
      nxt = num_rebuild(word, len);
`endif
    end else if (step) begin
      nxt = num_step(cur, ch);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cur <= ZERO;
    else         cur <= nxt;
  end

  assign valid = cur.dg & ~cur.tb;
  assign value = valid ? cur.acc[U-1:0] : '0;

endmodule

// File: rtl/shop_tokenizer.sv
// Byte-serial ASCII tokenizer feeding the shop command FSM.
// In: i_clk, i_reset, i_valid, i_char. Out: o_ready, o_rdy, o_a, o_u,
// o_u_valid, o_err_overflow. Macro SHOP_TOKENIZER_BACKSPACE_EN adds
// backspace (0x08/0x7F) editing.
module shop_tokenizer
  import shop_pkg::*;
#(
  parameter int NUM_ASCII_CHARS = DEF_NUM_ASCII_CHARS,
  parameter int A_NUM_BITS      = NUM_ASCII_CHARS * 8,
  parameter int U_NUM_BITS      = DEF_U_NUM_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [7:0]            i_char,
  output logic                  o_rdy,
  output logic [A_NUM_BITS-1:0] o_a,
  output logic [U_NUM_BITS-1:0] o_u,
  output logic                  o_u_valid,
  output logic                  o_err_overflow
);

  localparam int CW = $clog2(NUM_ASCII_CHARS + 1);

  tok_state_t            state, state_n;
  logic [A_NUM_BITS-1:0] word, word_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  ovf, ovf_n;
  logic                  clr, load, step;
  logic                  xfer, prt, dlm;
  logic [U_NUM_BITS-1:0] acc_val;
  logic                  acc_ok;
`ifdef SHOP_TOKENIZER_BACKSPACE_EN
  logic                  recalc;
  logic                  bsp;
  assign bsp = is_bksp(i_char);
`endif

  assign o_ready = (state != EMIT);
  assign xfer    = i_valid & o_ready;
  assign prt     = is_print(i_char);
  assign dlm     = is_delim(i_char);

  always_comb begin
    state_n = state;
    word_n  = word;
    cnt_n   = cnt;
    ovf_n   = ovf;
    clr     = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
`ifdef SHOP_TOKENIZER_BACKSPACE_EN
    recalc  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (xfer && prt) begin
          word_n  = A_NUM_BITS'(i_char);
          cnt_n   = CW'(1);
          load    = 1'b1;
          ovf_n   = 1'b0;
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          unique case (1'b1)
            prt: begin
              if (cnt == CW'(NUM_ASCII_CHARS)) begin
                ovf_n   = 1'b1;
                state_n = DRAIN;
              end else begin
                word_n = {word[A_NUM_BITS-9:0], i_char};
                cnt_n  = cnt + CW'(1);
                step   = 1'b1;
              end
            end
            dlm: state_n = EMIT;
`ifdef SHOP_TOKENIZER_BACKSPACE_EN
            bsp: begin
              if (cnt > CW'(1)) begin
                word_n = word >> 8;
                cnt_n  = cnt - CW'(1);
                recalc = 1'b1;
              end else begin
                state_n = IDLE;
              end
            end
`endif
            default: ;
          endcase
        end
      end
      EMIT: begin
        clr     = 1'b1;
        ovf_n   = 1'b0;
        state_n = IDLE;
      end
      DRAIN: begin
        if (xfer && dlm) state_n = EMIT;
      end
      default: state_n = IDLE;
    endcase
  end

  shop_dec_acc #(
    .N (NUM_ASCII_CHARS),
    .U (U_NUM_BITS)
  ) u_acc (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clr     (clr),
    .load    (load),
    .step    (step),
    .ch      (i_char),
`ifdef SHOP_TOKENIZER_BACKSPACE_EN
    .recalc  (recalc),
    .word    (word_n),
    .len     (cnt_n),
`endif
    .value   (acc_val),
    .valid   (acc_ok)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      word  <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      word  <= word_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end

  // An overflowed token reuses the EMIT slot but leaves o_a/o_u alone.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rdy          <= 1'b0;
      o_err_overflow <= 1'b0;
      o_a            <= '0;
      o_u            <= '0;
      o_u_valid      <= 1'b0;
    end else begin
      o_rdy          <= 1'b0;
      o_err_overflow <= 1'b0;
      if (state == EMIT) begin
        if (ovf) begin
          o_err_overflow <= 1'b1;
        end else begin
          o_rdy     <= 1'b1;
          o_a       <= word;
          o_u       <= acc_val;
          o_u_valid <= acc_ok;
        end
      end
    end
  end

endmodule

// File: tb/tb_shop_tokenizer.sv
// Directed self-checking bench for shop_tokenizer.
// Drives byte strings, watches pulses on the falling edge, asserts results.
module tb_shop_tokenizer;

  localparam int N = 7;
  localparam int A = N * 8;
  localparam int U = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic [7:0]   i_char;
  logic         o_ready;
  logic         o_rdy;
  logic [A-1:0] o_a;
  logic [U-1:0] o_u;
  logic         o_u_valid;
  logic         o_err_overflow;

  always #5 clk = ~clk;

  shop_tokenizer #(
    .NUM_ASCII_CHARS (N),
    .U_NUM_BITS      (U)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_char         (i_char),
    .o_rdy          (o_rdy),
    .o_a            (o_a),
    .o_u            (o_u),
    .o_u_valid      (o_u_valid),
    .o_err_overflow (o_err_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int           rdy_cnt  = 0;
  int           err_cnt  = 0;
  int           hold_cnt = 0;
  logic [A-1:0] cap_a    = '0;
  logic [A-1:0] prev_a   = '0;
  logic [U-1:0] cap_u    = '0;
  logic         cap_uv   = 1'b0;

  always @(negedge clk) begin
    if (o_rdy) begin
      rdy_cnt++;
      prev_a = cap_a;
      cap_a  = o_a;
      cap_u  = o_u;
      cap_uv = o_u_valid;
    end
    if (o_err_overflow) err_cnt++;
    if (!o_ready) hold_cnt++;
  end

  int r0, e0, h0;

  task automatic mark();
    r0 = rdy_cnt;
    e0 = err_cnt;
    h0 = hold_cnt;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte is held until a rising edge sees o_ready high.
  task automatic send(logic [7:0] c);
    logic acc;
    acc     = 1'b0;
    i_valid = 1'b1;
    i_char  = c;
    for (int k = 0; k < 5 && !acc; k++) begin
      acc = o_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic gap();
    i_valid = 1'b0;
    i_char  = 8'h00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_char  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(o_rdy), 64'd0);
    chk("rst_a", 64'(o_a), 64'd0);
    chk("rst_u", 64'(o_u), 64'd0);
    chk("rst_uv", 64'(o_u_valid), 64'd0);
    chk("rst_err", 64'(o_err_overflow), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    mark();
    send_str("Login\r");
    gap();
    chk("login_n", 64'(rdy_cnt - r0), 64'd1);
    chk("login_a", 64'(cap_a), 64'h004C6F67696E);
    chk("login_uv", 64'(cap_uv), 64'd0);
    chk("login_hold", 64'(hold_cnt - h0), 64'd1);

    mark();
    send_str("  12 ");
    gap();
    chk("n12_n", 64'(rdy_cnt - r0), 64'd1);
    chk("n12_a", 64'(cap_a), 64'h3132);
    chk("n12_u", 64'(cap_u), 64'd12);
    chk("n12_uv", 64'(cap_uv), 64'd1);

    mark();
    send_str("16\n");
    gap();
    chk("n16_n", 64'(rdy_cnt - r0), 64'd1);
    chk("n16_u", 64'(cap_u), 64'd0);
    chk("n16_uv", 64'(cap_uv), 64'd0);

    mark();
    send_str("15 ");
    gap();
    chk("n15_u", 64'(cap_u), 64'd15);
    chk("n15_uv", 64'(cap_uv), 64'd1);

    mark();
    send_str("0 ");
    gap();
    chk("n0_a", 64'(cap_a), 64'h30);
    chk("n0_u", 64'(cap_u), 64'd0);
    chk("n0_uv", 64'(cap_uv), 64'd1);

    mark();
    send_str("1234567 ");
    gap();
    chk("full_n", 64'(rdy_cnt - r0), 64'd1);
    chk("full_a", 64'(cap_a), 64'h31323334353637);
    chk("full_uv", 64'(cap_uv), 64'd0);
    chk("full_err", 64'(err_cnt - e0), 64'd0);

    mark();
    send_str("AddItems X ");
    gap();
    chk("ovf_err", 64'(err_cnt - e0), 64'd1);
    chk("ovf_n", 64'(rdy_cnt - r0), 64'd1);
    chk("ovf_a", 64'(cap_a), 64'h58);

    mark();
    send_str("AB\n\nCD ");
    gap();
    chk("bp_n", 64'(rdy_cnt - r0), 64'd2);
    chk("bp_hold", 64'(hold_cnt - h0), 64'd2);
    chk("bp_a0", 64'(prev_a), 64'h4142);
    chk("bp_a1", 64'(cap_a), 64'h4344);

    mark();
    send_str("A");
    send(8'h01);
    send_str("B ");
    gap();
    chk("np_n", 64'(rdy_cnt - r0), 64'd1);
    chk("np_a", 64'(cap_a), 64'h4142);

    mark();
    send_str("Ad");
    i_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_a", 64'(o_a), 64'd0);
    chk("mrst_rdy", 64'(o_rdy), 64'd0);
    rst = 1'b0;
    gap();
    chk("mrst_n", 64'(rdy_cnt - r0), 64'd0);
    send_str("Buy ");
    gap();
    chk("buy_n", 64'(rdy_cnt - r0), 64'd1);
    chk("buy_a", 64'(cap_a), 64'h427579);

    mark();
    send_str("Buz");
    send(8'h08);
    send_str("y ");
    gap();
    chk("bs_n", 64'(rdy_cnt - r0), 64'd1);
`ifdef SHOP_TOKENIZER_BACKSPACE_EN
    chk("bs_a", 64'(cap_a), 64'h427579);

    send_str("17");
    send(8'h7F);
    send_str(" ");
    gap();
    chk("bs_num_a", 64'(cap_a), 64'h31);
    chk("bs_num_u", 64'(cap_u), 64'd1);
    chk("bs_num_uv", 64'(cap_uv), 64'd1);
`else
    chk("bs_a", 64'(cap_a), 64'h42757A79);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
